// File: rtl/bitty_mem_arbiter.sv
// Two-master arbiter for one single-port synchronous memory.
// Data (m1) has priority; fetch (m0) wins after STARVE_LIMIT denials.
module bitty_mem_arbiter #(
    parameter int AW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_sel,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          s_ce,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [31:0]   s_wdata,
    output logic [3:0]    s_sel,
    input  logic [31:0]   s_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;
    logic       resp_pend_q, resp_pend_d;
    logic       resp_owner_q, resp_owner_d;
    logic       force_m0;

    assign force_m0 = (starve_q >= LIMIT);

    // Grants are gated by rst so nothing reaches the macro during reset.
    assign m0_gnt = rst & m0_req & (~m1_req | force_m0);
    assign m1_gnt = rst & m1_req & ~m0_gnt;
    assign s_ce   = m0_gnt | m1_gnt;

    always_comb begin
        s_we    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_sel   = '0;
        unique case (1'b1)
            m1_gnt: begin
                s_we    = m1_we;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                s_sel   = m1_sel;
            end
            m0_gnt: begin
                s_addr  = m0_addr;
                s_sel   = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        starve_d = '0;
        if (m0_req && !m0_gnt) begin
            starve_d = force_m0 ? starve_q : starve_q + 4'd1;
        end
        resp_pend_d  = s_ce & ~s_we;
        resp_owner_d = m1_gnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q     <= '0;
            resp_pend_q  <= 1'b0;
            resp_owner_q <= 1'b0;
        end else begin
            starve_q     <= starve_d;
            resp_pend_q  <= resp_pend_d;
            resp_owner_q <= resp_owner_d;
        end
    end

    assign m0_rvalid = resp_pend_q & ~resp_owner_q;
    assign m1_rvalid = resp_pend_q & resp_owner_q;
    assign m0_rdata  = m0_rvalid ? s_rdata : 32'h0;
    assign m1_rdata  = m1_rvalid ? s_rdata : 32'h0;

endmodule

// File: tb/tb_bitty_mem_arbiter.sv
// Scoreboard bench for bitty_mem_arbiter with a small byte-enabled memory.
// Predicted read responses are queued at grant and checked one cycle later.
module tb_bitty_mem_arbiter;

    localparam int AW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [31:0]   m0_rdata;
    logic          m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [31:0]   m1_wdata, m1_rdata;
    logic [3:0]    m1_sel;
    logic          s_ce, s_we;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata;
    logic [3:0]    s_sel;
    logic [31:0]   s_rdata = 32'h0;

    always #5 clk = ~clk;

    bitty_mem_arbiter #(.AW(AW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_sel(m1_sel), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_ce(s_ce), .s_we(s_we), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_sel(s_sel), .s_rdata(s_rdata)
    );

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
    } resp_t;

    resp_t       q[$];
    logic [31:0] mem[16];
    logic [31:0] sh[16];
    int          checks = 0;
    int          errors = 0;
    int          st = 0;

    always @(posedge clk) begin
        if (s_ce && s_we) begin
            for (int b = 0; b < 4; b++)
                if (s_sel[b]) mem[s_addr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
        end else if (s_ce) begin
            s_rdata <= mem[s_addr[5:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic a0r, input logic [31:0] a0,
                        input logic a1r, input logic we, input logic [31:0] a1,
                        input logic [31:0] wd, input logic [3:0] sel,
                        output logic g0);
        logic  e0, e1;
        resp_t p;
        @(posedge clk);
        #1;
        rst = r; m0_req = a0r; m0_addr = a0;
        m1_req = a1r; m1_we = we; m1_addr = a1;
        m1_wdata = wd; m1_sel = sel;
        e0 = r & a0r & (~a1r | (st >= LIM));
        e1 = r & a1r & ~e0;
        @(negedge clk);
        if (!r) q.delete();
        chk("m0_gnt", 32'(m0_gnt), 32'(e0));
        chk("m1_gnt", 32'(m1_gnt), 32'(e1));
        chk("s_ce", 32'(s_ce), 32'(e0 | e1));
        chk("s_we", 32'(s_we), 32'(e1 & we));
        chk("s_addr", s_addr, e1 ? a1 : (e0 ? a0 : 32'h0));
        chk("s_wdata", s_wdata, e1 ? wd : 32'h0);
        chk("s_sel", 32'(s_sel), e1 ? 32'(sel) : (e0 ? 32'hf : 32'h0));
        chk("both_rv", 32'(m0_rvalid & m1_rvalid), 32'h0);
        if (q.size() > 0) begin
            p = q.pop_front();
            chk("m0_rvalid", 32'(m0_rvalid), 32'(!p.owner));
            chk("m1_rvalid", 32'(m1_rvalid), 32'(p.owner));
            chk("m0_rdata", m0_rdata, p.owner ? 32'h0 : p.data);
            chk("m1_rdata", m1_rdata, p.owner ? p.data : 32'h0);
        end else begin
            chk("m0_rvalid_idle", 32'(m0_rvalid), 32'h0);
            chk("m1_rvalid_idle", 32'(m1_rvalid), 32'h0);
        end
        if (!r) st = 0;
        else if (a0r && !e0) st = (st < LIM) ? st + 1 : st;
        else st = 0;
        if (e1 && we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) sh[a1[5:2]][8*b +: 8] = wd[8*b +: 8];
        end else if (e1) begin
            q.push_back('{owner: 1'b1, data: sh[a1[5:2]]});
        end else if (e0) begin
            q.push_back('{owner: 1'b0, data: sh[a0[5:2]]});
        end
        g0 = m0_gnt;
    endtask

    task automatic idle(input int n);
        logic g;
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, g);
    endtask

    logic [9:0] pat;
    logic       g;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            sh[i]  = mem[i];
        end
        mem[4] = 32'hDEADBEEF;
        sh[4]  = 32'hDEADBEEF;
        rst = 1'b0; m0_req = 0; m0_addr = 0; m1_req = 0; m1_we = 0;
        m1_addr = 0; m1_wdata = 0; m1_sel = 0;

        step(0, 1, 32'h10, 1, 1, 32'h40, 32'hFFFF_FFFF, 4'hf, g);
        step(0, 1, 32'h10, 0, 0, 0, 0, 0, g);
        idle(1);

        step(1, 1, 32'h10, 0, 0, 0, 0, 0, g);
        chk("m0_first_gnt", 32'(g), 32'h1);
        idle(1);

        pat = '0;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 32'h14, 1, 0, 32'h20, 0, 4'hf, g);
            pat[i] = g;
        end
        chk("starve_pat", 32'(pat), 32'h210);
        idle(1);

        step(1, 0, 0, 1, 1, 32'h100, 32'h12345678, 4'b0011, g);
        idle(1);
        step(1, 0, 0, 1, 0, 32'h100, 0, 4'hf, g);
        idle(1);

        step(1, 0, 0, 1, 0, 32'h24, 0, 4'hf, g);
        step(1, 1, 32'h28, 0, 0, 0, 0, 0, g);
        idle(1);

        step(1, 1, 32'h10, 0, 0, 0, 0, 0, g);
        step(0, 0, 0, 0, 0, 0, 0, 0, g);
        idle(2);
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 32'h18, 1, 0, 32'h1C, 0, 4'hf, g);
            pat[i] = g;
        end
        chk("starve_after_rst", 32'(pat), 32'h10);
        idle(1);

        step(1, 1, 32'h30, 1, 0, 32'h34, 0, 4'hf, g);
        step(1, 1, 32'h30, 1, 0, 32'h34, 0, 4'hf, g);
        step(1, 1, 32'h30, 0, 0, 0, 0, 0, g);
        chk("m0_gnt_on_drop", 32'(g), 32'h1);
        idle(1);

        for (int i = 0; i < 60; i++) begin
            step(1, 1'($urandom_range(0, 1)),
                 {26'h0, 4'($urandom_range(0, 15)), 2'b00},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 {26'h0, 4'($urandom_range(0, 15)), 2'b00},
                 $urandom, 4'($urandom_range(0, 15)), g);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
